// File: rtl/mem_arbiter.sv
// Main-memory port arbiter: dcache has priority, icache MSHR gets a
// reserved cycle after STARVE_LIMIT back-to-back dcache grants. Returned
// transaction tags and data tags are steered to whichever side owns them.

package mem_arbiter_pkg;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned TAG_W   = 4;
    localparam int unsigned TAGS    = 16;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_command_e;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [BLOCK_W-1:0] mem_block_t;
    typedef logic [TAG_W-1:0]   mem_tag_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  mem_command_e dcache_command,
    input  addr_t        dcache_addr,
    input  mem_block_t   dcache_data,
    input  mem_command_e icache_command,
    input  addr_t        icache_addr,
    input  mem_tag_t     mem2proc_transaction_tag,
    input  mem_block_t   mem2proc_data,
    input  mem_tag_t     mem2proc_data_tag,
    output mem_command_e proc2mem_command,
    output addr_t        proc2mem_addr,
    output mem_block_t   proc2mem_data,
    output logic         dcache_request,
    output logic         dcache_grant,
    output mem_tag_t     Dmem2proc_transaction_tag,
    output mem_block_t   Dmem2proc_data,
    output mem_tag_t     Dmem2proc_data_tag,
    output mem_tag_t     Imem2proc_transaction_tag,
    output mem_block_t   Imem2proc_data,
    output mem_tag_t     Imem2proc_data_tag
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        GRANT_NONE      = 2'd0,
        GRANT_DCACHE_LD = 2'd1,
        GRANT_DCACHE_ST = 2'd2,
        GRANT_ICACHE    = 2'd3
    } grant_e;

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    grant_e           last_grant_q, last_grant_d;
    logic [TAGS-1:0]  valid_q, valid_d;
    logic [TAGS-1:0]  owner_icache_q, owner_icache_d;

    logic reserve_c;
    logic dgrant_c;
    logic igrant_c;

    // Grant decision, memory drive, tag steering and next-state computation
    always_comb begin
        starve_cnt_d              = starve_cnt_q;
        last_grant_d              = last_grant_q;
        valid_d                   = valid_q;
        owner_icache_d            = owner_icache_q;
        proc2mem_command          = MEM_NONE;
        proc2mem_addr             = '0;
        proc2mem_data             = '0;
        Dmem2proc_transaction_tag = '0;
        Imem2proc_transaction_tag = '0;
        Dmem2proc_data_tag        = '0;
        Imem2proc_data_tag        = '0;
        Dmem2proc_data            = mem2proc_data;
        Imem2proc_data            = mem2proc_data;

        // Reset overrides every input so nothing leaks out in the reset cycle.
        reserve_c = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
        dgrant_c  = !reset && (dcache_command != MEM_NONE) && !reserve_c;
        igrant_c  = !reset && !dgrant_c && (icache_command != MEM_NONE);

        if (dgrant_c) begin
            proc2mem_command = dcache_command;
            proc2mem_addr    = dcache_addr;
            proc2mem_data    = dcache_data;
        end else if (igrant_c) begin
            proc2mem_command = icache_command;
            proc2mem_addr    = icache_addr;
        end

        if (reserve_c)     starve_cnt_d = '0;
        else if (dgrant_c) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        else               starve_cnt_d = '0;

        if (dgrant_c)
            last_grant_d = (dcache_command == MEM_STORE) ? GRANT_DCACHE_ST : GRANT_DCACHE_LD;
        else if (igrant_c)
            last_grant_d = GRANT_ICACHE;
        else
            last_grant_d = GRANT_NONE;

        if (!reset) begin
            unique case (last_grant_q)
                GRANT_DCACHE_LD,
                GRANT_DCACHE_ST: Dmem2proc_transaction_tag = mem2proc_transaction_tag;
                GRANT_ICACHE:    Imem2proc_transaction_tag = mem2proc_transaction_tag;
                default:         ;
            endcase

            // Lookup uses the pre-update entry; the clear precedes allocation.
            if (mem2proc_data_tag != '0 && valid_q[mem2proc_data_tag]) begin
                if (owner_icache_q[mem2proc_data_tag]) Imem2proc_data_tag = mem2proc_data_tag;
                else                                   Dmem2proc_data_tag = mem2proc_data_tag;
                valid_d[mem2proc_data_tag] = 1'b0;
            end

            // Only loads are tracked; stores and rejected (tag 0) are not.
            if (mem2proc_transaction_tag != '0 &&
                (last_grant_q == GRANT_DCACHE_LD || last_grant_q == GRANT_ICACHE)) begin
                valid_d[mem2proc_transaction_tag]        = 1'b1;
                owner_icache_d[mem2proc_transaction_tag] = (last_grant_q == GRANT_ICACHE);
            end
        end

        dcache_grant   = dgrant_c;
        dcache_request = dgrant_c;
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q   <= '0;
            last_grant_q   <= GRANT_NONE;
            valid_q        <= '0;
            owner_icache_q <= '0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            last_grant_q   <= last_grant_d;
            valid_q        <= valid_d;
            owner_icache_q <= owner_icache_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (STARVE_LIMIT = 8).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    mem_command_e dcache_command, icache_command, proc2mem_command;
    addr_t        dcache_addr, icache_addr, proc2mem_addr;
    mem_block_t   dcache_data, mem2proc_data, proc2mem_data;
    mem_block_t   Dmem2proc_data, Imem2proc_data;
    mem_tag_t     mem2proc_transaction_tag, mem2proc_data_tag;
    mem_tag_t     Dmem2proc_transaction_tag, Dmem2proc_data_tag;
    mem_tag_t     Imem2proc_transaction_tag, Imem2proc_data_tag;
    logic         dcache_request, dcache_grant;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.STARVE_LIMIT(8)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .dcache_command            (dcache_command),
        .dcache_addr               (dcache_addr),
        .dcache_data               (dcache_data),
        .icache_command            (icache_command),
        .icache_addr               (icache_addr),
        .mem2proc_transaction_tag  (mem2proc_transaction_tag),
        .mem2proc_data             (mem2proc_data),
        .mem2proc_data_tag         (mem2proc_data_tag),
        .proc2mem_command          (proc2mem_command),
        .proc2mem_addr             (proc2mem_addr),
        .proc2mem_data             (proc2mem_data),
        .dcache_request            (dcache_request),
        .dcache_grant              (dcache_grant),
        .Dmem2proc_transaction_tag (Dmem2proc_transaction_tag),
        .Dmem2proc_data            (Dmem2proc_data),
        .Dmem2proc_data_tag        (Dmem2proc_data_tag),
        .Imem2proc_transaction_tag (Imem2proc_transaction_tag),
        .Imem2proc_data            (Imem2proc_data),
        .Imem2proc_data_tag        (Imem2proc_data_tag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        dcache_command = MEM_NONE; dcache_addr = '0; dcache_data = '0;
        icache_command = MEM_NONE; icache_addr = '0;
        mem2proc_transaction_tag = '0; mem2proc_data_tag = '0; mem2proc_data = '0;
    endtask

    task automatic chk_mem(input string name, input mem_command_e cmd, input logic [31:0] addr,
                           input logic [63:0] data, input logic req);
        chk({name, "_cmd"},  64'(proc2mem_command), 64'(cmd));
        chk({name, "_addr"}, 64'(proc2mem_addr),    64'(addr));
        chk({name, "_data"}, 64'(proc2mem_data),    data);
        chk({name, "_req"},  64'(dcache_request),   64'(req));
        chk({name, "_gnt"},  64'(dcache_grant),     64'(req));
    endtask

    task automatic chk_tags(input string name, input logic [3:0] dt, input logic [3:0] it,
                            input logic [3:0] dd, input logic [3:0] id);
        chk({name, "_dtx"},   64'(Dmem2proc_transaction_tag), 64'(dt));
        chk({name, "_itx"},   64'(Imem2proc_transaction_tag), 64'(it));
        chk({name, "_ddtag"}, 64'(Dmem2proc_data_tag),        64'(dd));
        chk({name, "_idtag"}, 64'(Imem2proc_data_tag),        64'(id));
    endtask

    initial begin
        // Reset with busy inputs: everything must still be quiet.
        reset = 1'b1;
        idle();
        dcache_command = MEM_LOAD; dcache_addr = 32'h55; icache_command = MEM_LOAD;
        mem2proc_transaction_tag = 4'd5; mem2proc_data_tag = 4'd5;
        @(negedge clock); #1;
        chk_mem("rst", MEM_NONE, 32'h0, 64'h0, 1'b0);
        chk_tags("rst", 4'd0, 4'd0, 4'd0, 4'd0);

        @(negedge clock); reset = 1'b0; idle(); #1;
        chk_mem("idle", MEM_NONE, 32'h0, 64'h0, 1'b0);
        chk_tags("idle", 4'd0, 4'd0, 4'd0, 4'd0);

        // icache load alone, tag 3, then data for tag 3.
        @(negedge clock); idle(); icache_command = MEM_LOAD; icache_addr = 32'h100; #1;
        chk_mem("iload", MEM_LOAD, 32'h100, 64'h0, 1'b0);
        @(negedge clock); idle(); mem2proc_transaction_tag = 4'd3; #1;
        chk_tags("itag3", 4'd0, 4'd3, 4'd0, 4'd0);
        @(negedge clock); idle(); mem2proc_data_tag = 4'd3; mem2proc_data = 64'hDEAD_BEEF; #1;
        chk_tags("idata3", 4'd0, 4'd0, 4'd0, 4'd3);
        chk("idata3_ddata", Dmem2proc_data, 64'hDEAD_BEEF);
        chk("idata3_idata", Imem2proc_data, 64'hDEAD_BEEF);
        @(negedge clock); idle(); mem2proc_data_tag = 4'd3; #1;
        chk_tags("data3_again", 4'd0, 4'd0, 4'd0, 4'd0);

        // Collision: dcache wins; then tag 7 allocates for dcache.
        @(negedge clock); idle();
        dcache_command = MEM_LOAD; dcache_addr = 32'h200; dcache_data = 64'h11;
        icache_command = MEM_LOAD; icache_addr = 32'h300; #1;
        chk_mem("collide", MEM_LOAD, 32'h200, 64'h11, 1'b1);
        @(negedge clock); idle(); mem2proc_transaction_tag = 4'd7; #1;
        chk_tags("dtag7", 4'd7, 4'd0, 4'd0, 4'd0);

        // Continuous dcache with waiting icache: cycle 9 is reserved.
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock); idle();
            dcache_command = MEM_LOAD; dcache_addr = 32'h500;
            icache_command = MEM_LOAD; icache_addr = 32'h400; #1;
            if (i == 9) chk_mem($sformatf("starve%0d", i), MEM_LOAD, 32'h400, 64'h0, 1'b0);
            else        chk_mem($sformatf("starve%0d", i), MEM_LOAD, 32'h500, 64'h0, 1'b1);
            if (i == 10) chk_tags("rejected_itx", 4'd0, 4'd0, 4'd0, 4'd0);
        end

        // dcache store: routed tag 5 but no ownership recorded.
        @(negedge clock); idle();
        dcache_command = MEM_STORE; dcache_addr = 32'h600; dcache_data = 64'hCAFE; #1;
        chk_mem("store", MEM_STORE, 32'h600, 64'hCAFE, 1'b1);
        @(negedge clock); idle(); mem2proc_transaction_tag = 4'd5; #1;
        chk_tags("stag5", 4'd5, 4'd0, 4'd0, 4'd0);
        @(negedge clock); idle(); mem2proc_data_tag = 4'd5; #1;
        chk_tags("sdata5", 4'd0, 4'd0, 4'd0, 4'd0);

        // Tag 7 returns to dcache while being reallocated to icache.
        @(negedge clock); idle(); icache_command = MEM_LOAD; icache_addr = 32'h700; #1;
        chk_mem("iload7", MEM_LOAD, 32'h700, 64'h0, 1'b0);
        @(negedge clock); idle(); mem2proc_transaction_tag = 4'd7; mem2proc_data_tag = 4'd7; #1;
        chk_tags("same7", 4'd0, 4'd7, 4'd7, 4'd0);
        @(negedge clock); idle(); mem2proc_data_tag = 4'd7; #1;
        chk_tags("realloc7", 4'd0, 4'd0, 4'd0, 4'd7);

        // Reset drops ownership of outstanding tag 9.
        @(negedge clock); idle(); icache_command = MEM_LOAD; icache_addr = 32'h800; #1;
        chk_mem("iload9", MEM_LOAD, 32'h800, 64'h0, 1'b0);
        @(negedge clock); idle(); mem2proc_transaction_tag = 4'd9; #1;
        chk_tags("itag9", 4'd0, 4'd9, 4'd0, 4'd0);
        @(negedge clock); idle(); reset = 1'b1; dcache_command = MEM_LOAD; dcache_addr = 32'h900; #1;
        chk_mem("rst2", MEM_NONE, 32'h0, 64'h0, 1'b0);
        @(negedge clock); idle(); reset = 1'b0; mem2proc_data_tag = 4'd9; #1;
        chk_tags("post_rst9", 4'd0, 4'd0, 4'd0, 4'd0);

        @(negedge clock); idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the dcache (priority requester) and the icache MSHR.
- Drives the icache's dcache_request input, so the icache issues a request only in cycles the port is free for it.
- Registers which requester was granted, steers the returned transaction tag to that requester, and records tag ownership in a 16-entry table so returning data/data-tag go only to the owner.
- Bounded starvation: after STARVE_LIMIT consecutive dcache grants, one cycle is reserved for the icache.

Parameters:
- STARVE_LIMIT, 8, max consecutive cycles the dcache holds the port before one icache-reserved cycle (range 1..255).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- dcache_command  in  MEM_COMMAND  dcache request (MEM_NONE/MEM_LOAD/MEM_STORE)
- dcache_addr  in  ADDR  dcache request address
- dcache_data  in  MEM_BLOCK  dcache store data
- icache_command  in  MEM_COMMAND  icache MSHR request (MEM_NONE/MEM_LOAD)
- icache_addr  in  ADDR  icache MSHR request address
- mem2proc_transaction_tag  in  MEM_TAG  tag for previous cycle's command; 0 = rejected
- mem2proc_data  in  MEM_BLOCK  returning load data
- mem2proc_data_tag  in  MEM_TAG  tag of returning data; 0 = none
- proc2mem_command  out  MEM_COMMAND  command to memory
- proc2mem_addr  out  ADDR  address to memory
- proc2mem_data  out  MEM_BLOCK  store data to memory
- dcache_request  out  1  to icache: port taken by dcache this cycle
- dcache_grant  out  1  dcache command driven to memory this cycle
- Dmem2proc_transaction_tag  out  MEM_TAG  dcache copy of transaction tag
- Dmem2proc_data  out  MEM_BLOCK  dcache copy of data
- Dmem2proc_data_tag  out  MEM_TAG  data tag; nonzero only if owner is dcache
- Imem2proc_transaction_tag  out  MEM_TAG  icache copy of transaction tag
- Imem2proc_data  out  MEM_BLOCK  icache copy of data
- Imem2proc_data_tag  out  MEM_TAG  data tag; nonzero only if owner is icache

Behaviour:
- Grant (combinational, current cycle): reserve = (starve_cnt == STARVE_LIMIT). dcache_grant = (dcache_command != MEM_NONE) && !reserve. dcache_request = dcache_grant. icache_grant = !dcache_grant && icache_command != MEM_NONE.
- icache_grant uses icache_command. icache_command depends on dcache_request, which is computed from registered state and dcache_command only, so there is no combinational loop.
- Memory drive: dcache_grant -> proc2mem_* = dcache_*. Else icache_grant -> proc2mem_command/addr = icache_*, proc2mem_data = 0. Else MEM_NONE, addr 0, data 0.
- starve_cnt (8-bit register):
  - reserve cycle -> 0.
  - else dcache_grant -> +1.
  - else -> 0.
  - A reserve cycle is spent even if the icache is idle.
- last_grant register: {NONE, DCACHE_LD, DCACHE_ST, ICACHE}, set from this cycle's grant and command.
- Transaction tag routing (next cycle):
  - last_grant DCACHE_* -> Dmem2proc_transaction_tag = mem2proc_transaction_tag, Imem2proc_transaction_tag = 0.
  - last_grant ICACHE -> the mirror of the above.
  - last_grant NONE -> both 0.
- Ownership table: 16 entries {valid, owner}.
  - Nonzero transaction tag with last_grant DCACHE_LD or ICACHE -> entry[tag] = {1, owner}.
  - Stores and tag 0 (rejected) are not recorded; the requester retries.
- Data return, when mem2proc_data_tag != 0:
  - Look up the pre-update entry. Valid -> drive the owner's data_tag = mem2proc_data_tag; the other side's data_tag = 0; clear the entry.
  - Invalid entry -> both data tags 0.
- Dmem2proc_data and Imem2proc_data always mirror mem2proc_data.
- Same cycle, same tag: clear from the data return happens first, then allocation; allocation wins.
- Tag 0 is never stored or looked up.
- Reset:
  - Table cleared, starve_cnt = 0, last_grant = NONE.
  - All tag outputs 0, proc2mem_command = MEM_NONE, addr/data 0, dcache_grant/dcache_request 0.
  - This is required regardless of inputs in the reset cycle.
  - Reset mid-transaction drops all ownership; later data returns for those tags route nowhere.
- The icache squash resets only the icache. The arbiter keeps the entry and still steers the returning tag to the icache, which ignores it.

Test Plan:
- Reset, then icache LOAD 0x100 alone -> proc2mem_command = MEM_LOAD, addr 0x100; next cycle mem tag 3 -> Imem2proc_transaction_tag = 3, Dmem tag 0; later data_tag 3 -> Imem2proc_data_tag = 3, Dmem2proc_data_tag = 0, entry 3 cleared.
- dcache LOAD and icache LOAD same cycle -> dcache_request = 1, dcache_grant = 1, memory sees dcache addr; icache command ignored.
- dcache requests continuously, STARVE_LIMIT = 8 -> cycles 1-8 dcache granted; cycle 9 dcache_request = 0 and icache granted; cycle 10 dcache regains the port.
- dcache STORE gets tag 5, then data_tag 5 arrives -> no table entry, both data tags 0.
- Transaction tag 0 after icache grant -> no entry allocated; both transaction tag outputs 0.
- Data_tag 7 returns (owner dcache) in the same cycle transaction tag 7 allocates for icache -> Dmem2proc_data_tag = 7; entry 7 becomes {1, ICACHE}.
- Assert reset with entries valid -> data_tag for an old tag afterwards yields both data tags 0.
